pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//   Owns the fetch PC register of the pipelined miniRV core and sequences the NPC unit.
//   Each cycle it selects NPC_PC4 or NPC_new, drives npc_pc/npc_new_pc, and captures npc_in into the PC.
//   Arbitrates between three sources: EX-stage redirects (branch/jal/jalr), the hazard unit's stall, and IROM fetch handshake.
//   Raises IF/ID and ID/EX flushes after every redirect.
// PARAMETERS
//   RESET_PC      32'h0000_0000  PC value loaded by reset
//   FLUSH_CYCLES  2              cycles flush_if_id is held after a redirect (1..3)
// PORTS
//   clk             in   1   core clock, rising edge
//   rst             in   1   reset; asynchronous, active-high
//   stall           in   1   load-use stall from hazard unit; hold PC
//   redirect_valid  in   1   EX resolved a taken branch/jump this cycle
//   redirect_pc     in   32  target address of the redirect
//   fetch_ready     in   1   IROM accepts the current fetch this cycle
//   fetch_valid     out  1   fetch request for pc is valid
//   pc              out  32  current fetch PC (registered)
//   npc_pc          out  32  PC fed to NPC unit (= pc)
//   npc_op          out  1   NPC select: NPC_PC4 / NPC_new
//   npc_new_pc      out  32  redirect target fed to NPC unit (word-aligned)
//   npc_in          in   32  NPC result
//   flush_if_id     out  1   kill IF/ID register contents
//   flush_id_ex     out  1   kill ID/EX register contents
//   misalign_err    out  1   sticky: a redirect target had [1:0]!=0
//   redirect_cnt    out  16  saturating count of accepted redirects
// BEHAVIOUR
//   Reset values: pc=RESET_PC, state=BOOT, fetch_valid=0, flush_*=0, misalign_err=0, redirect_cnt=0.
//   Reset is honoured immediately, including mid-flush or mid-stall.
//   FSM states:
//     BOOT   one cycle after rst falls; fetch_valid=0; -> RUN.
//     RUN    fetch_valid=1.
//              PC <= npc_in (npc_op=NPC_PC4) on fetch_valid&fetch_ready&!stall.
//              Stall or !fetch_ready holds the PC.
//     FLUSH  fetch_valid=1; flush_if_id=1 while flush counter!=0.
//              The PC advances as in RUN. -> RUN when counter reaches 0.
//   Redirect, accepted in any state except BOOT:
//     npc_op=NPC_new the same cycle; PC <= npc_in on the next edge, regardless of stall/fetch_ready.
//     state <= FLUSH; counter <= FLUSH_CYCLES.
//     flush_id_ex=1 combinationally in the redirect cycle only.
//   Priority: rst > redirect > stall > fetch handshake.
//   Redirect together with stall: redirect wins; the stall is dropped for that cycle.
//   Redirect during FLUSH: accepted; counter reloads to FLUSH_CYCLES.
//   Redirect in BOOT: ignored (cannot occur in a legal pipeline).
//   An in-flight fetch not yet acked when a redirect arrives is abandoned; IROM must tolerate the request being withdrawn.
//   Alignment: npc_new_pc = {redirect_pc[31:2],2'b00}. If redirect_pc[1:0]!=0, misalign_err<=1 and stays set until rst.
//   redirect_cnt: +1 per accepted redirect; saturates at 16'hFFFF, no wrap.
//   PC arithmetic: 32-bit modulo (done by NPC); 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
//   Outputs pc, fetch_valid, flush_if_id are registered/state-decoded.
//   npc_op, npc_new_pc and flush_id_ex are combinational from the redirect inputs.
// STRUCTURE
//   defines.vh: NPC_PC4=1'b0, NPC_new=1'b1 (existing); add PCS_BOOT/PCS_RUN/PCS_FLUSH 2-bit encodings.
//   Sub-module flush_timer (load, count value, busy) holds the flush counter.
//   The NPC unit remains external; pc_sequencer only drives and samples it.
// TESTING
//   Reset release, fetch_ready=1, no stall:
//     cycle0 fetch_valid=0; then pc=0,4,8,C on successive edges.
//   stall=1 for 3 cycles at pc=0x10: pc holds 0x10 for 3 cycles; npc_op=NPC_PC4; no flush.
//   redirect_valid=1, redirect_pc=0x100 together with stall=1 at pc=0x20:
//     npc_op=NPC_new and flush_id_ex=1 that cycle.
//     pc=0x100 next edge; flush_if_id=1 for 2 cycles; redirect_cnt=1.
//   Second redirect to 0x200 one cycle into FLUSH: pc=0x200; flush_if_id held 2 more cycles.
//   redirect_pc=0x103: npc_new_pc=0x100; pc=0x100; misalign_err=1, still set 10 cycles later.
//   fetch_ready=0 for 4 cycles at pc=0x40: pc holds; fetch_valid stays 1.
//     Assert rst mid-hold: pc=RESET_PC immediately (async); fetch_valid=0.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the fetch PC sequencer: NPC select codes and FSM states.
package pc_sequencer_pkg;

  localparam logic NPC_PC4 = 1'b0;
  localparam logic NPC_NEW = 1'b1;

  localparam logic [15:0] REDIRECT_CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    PCS_BOOT  = 2'b00,
    PCS_RUN   = 2'b01,
    PCS_FLUSH = 2'b10
  } pcs_state_e;

  // Redirect targets are forced onto a word boundary before reaching the NPC.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_sequencer_flush_timer.sv
// Down-counter that holds the IF/ID flush window after a redirect.
// A load always wins over the count, so back-to-back redirects restart the window.
module pc_sequencer_flush_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         busy,
  output logic         last
);

  logic [W-1:0] cnt;

  // Reload on redirect, otherwise count down to zero and stop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             cnt <= '0;
    else if (load)       cnt <= value;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign busy = (cnt != '0);
  assign last = (cnt == W'(1));

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC owner for the pipelined miniRV core. Drives the external NPC unit,
// captures its result, and raises pipeline flushes after EX redirects.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        fetch_ready,
  output logic        fetch_valid,
  output logic [31:0] pc,
  output logic [31:0] npc_pc,
  output logic        npc_op,
  output logic [31:0] npc_new_pc,
  input  logic [31:0] npc_in,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        misalign_err,
  output logic [15:0] redirect_cnt
);

  pcs_state_e state, state_nxt;
  logic       redir;
  logic       advance;
  logic       ft_busy, ft_last;

  // A redirect showing up during BOOT is not a legal pipeline event and is dropped.
  assign redir       = redirect_valid && (state != PCS_BOOT);
  assign fetch_valid = (state != PCS_BOOT);
  // Redirect overrides stall and the fetch handshake; an unacked fetch is simply withdrawn.
  assign advance     = redir || (fetch_valid && fetch_ready && !stall);

  assign npc_pc      = pc;
  assign npc_op      = redir ? NPC_NEW : NPC_PC4;
  assign npc_new_pc  = word_align(redirect_pc);
  assign flush_id_ex = redir;
  assign flush_if_id = (state == PCS_FLUSH) && ft_busy;

  pc_sequencer_flush_timer #(.W(2)) u_flush_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (redir),
    .value (2'(FLUSH_CYCLES)),
    .busy  (ft_busy),
    .last  (ft_last)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= PCS_BOOT;
    else     state <= state_nxt;
  end

  // Next-state: BOOT lasts one cycle; FLUSH drains to RUN as the timer empties.
  always_comb begin
    state_nxt = state;
    case (state)
      PCS_BOOT:  state_nxt = PCS_RUN;
      PCS_RUN:   if (redir) state_nxt = PCS_FLUSH;
      PCS_FLUSH: begin
        if (redir)                    state_nxt = PCS_FLUSH;
        else if (ft_last || !ft_busy) state_nxt = PCS_RUN;
      end
      default:   state_nxt = PCS_BOOT;
    endcase
  end

  // PC capture from the NPC unit whenever the pipeline advances or is redirected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          pc <= RESET_PC;
    else if (advance) pc <= npc_in;
  end

  // Sticky misalignment flag and saturating redirect counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_err <= 1'b0;
      redirect_cnt <= '0;
    end else if (redir) begin
      if (redirect_pc[1:0] != 2'b00)         misalign_err <= 1'b1;
      if (redirect_cnt != REDIRECT_CNT_MAX)  redirect_cnt <= redirect_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a behavioural NPC unit in the loop.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, redirect_valid, fetch_ready;
  logic [31:0] redirect_pc;
  logic        fetch_valid, npc_op, flush_if_id, flush_id_ex, misalign_err;
  logic [31:0] pc, npc_pc, npc_new_pc, npc_in;
  logic [15:0] redirect_cnt;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  // External NPC unit: PC+4 or the supplied target.
  assign npc_in = npc_op ? npc_new_pc : (npc_pc + 32'd4);

  pc_sequencer #(.RESET_PC(32'h0), .FLUSH_CYCLES(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_ready    (fetch_ready),
    .fetch_valid    (fetch_valid),
    .pc             (pc),
    .npc_pc         (npc_pc),
    .npc_op         (npc_op),
    .npc_new_pc     (npc_new_pc),
    .npc_in         (npc_in),
    .flush_if_id    (flush_if_id),
    .flush_id_ex    (flush_id_ex),
    .misalign_err   (misalign_err),
    .redirect_cnt   (redirect_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance one edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; fetch_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_fv", fetch_valid, 0);
    check("rst_flush_if", flush_if_id, 0);
    check("rst_flush_ex", flush_id_ex, 0);
    check("rst_mis", misalign_err, 0);
    check("rst_cnt", redirect_cnt, 0);

    // Sequential fetch after boot.
    tick(); check("boot_pc0", pc, 32'h0); check("boot_fv", fetch_valid, 1);
    tick(); check("seq_pc4", pc, 32'h4);
    tick(); check("seq_pc8", pc, 32'h8);
    tick(); check("seq_pcC", pc, 32'hC);
    tick(); check("seq_pc10", pc, 32'h10);

    // Stall holds the PC.
    stall = 1'b1; #1;
    check("stall_op", npc_op, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); check("stall_hold", pc, 32'h10); check("stall_noflush", flush_if_id, 0);
    end
    stall = 1'b0;
    tick(); check("stall_rel", pc, 32'h14);
    repeat (3) tick();
    check("pre_redir_pc", pc, 32'h20);

    // Redirect with stall: redirect wins.
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
    check("redir_op", npc_op, 1);
    check("redir_flush_ex", flush_id_ex, 1);
    check("redir_newpc", npc_new_pc, 32'h100);
    tick(); stall = 1'b0; redirect_valid = 1'b0; #1;
    check("redir_pc", pc, 32'h100);
    check("redir_flush_if1", flush_if_id, 1);
    check("redir_cnt1", redirect_cnt, 1);
    check("redir_ex_drop", flush_id_ex, 0);

    // Second redirect one cycle into FLUSH reloads the window.
    redirect_valid = 1'b1; redirect_pc = 32'h200; #1;
    check("redir2_flush_ex", flush_id_ex, 1);
    tick(); redirect_valid = 1'b0; #1;
    check("redir2_pc", pc, 32'h200);
    check("redir2_flush_a", flush_if_id, 1);
    tick(); check("redir2_pc4", pc, 32'h204); check("redir2_flush_b", flush_if_id, 1);
    tick(); check("redir2_pc8", pc, 32'h208); check("redir2_flush_end", flush_if_id, 0);
    check("redir2_cnt", redirect_cnt, 2);

    // Misaligned target is word-aligned and flagged stickily.
    redirect_valid = 1'b1; redirect_pc = 32'h103; #1;
    check("mis_newpc", npc_new_pc, 32'h100);
    tick(); redirect_valid = 1'b0; #1;
    check("mis_pc", pc, 32'h100);
    check("mis_flag", misalign_err, 1);
    repeat (10) tick();
    check("mis_sticky", misalign_err, 1);
    check("mis_pc_adv", pc, 32'h128);

    // Top-of-memory wrap.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
    tick(); redirect_valid = 1'b0; #1;
    check("wrap_top", pc, 32'hFFFF_FFFC);
    tick(); check("wrap_zero", pc, 32'h0);

    // Fetch not ready holds PC; reset lands mid-hold.
    redirect_valid = 1'b1; redirect_pc = 32'h40; #1;
    tick(); redirect_valid = 1'b0; fetch_ready = 1'b0; #1;
    check("fr_pc", pc, 32'h40);
    check("fr_cnt", redirect_cnt, 5);
    tick(); check("fr_hold1", pc, 32'h40); check("fr_fv1", fetch_valid, 1);
    tick(); check("fr_hold2", pc, 32'h40); check("fr_fv2", fetch_valid, 1);
    #1 rst = 1'b1; #1;
    check("async_pc", pc, 32'h0);
    check("async_fv", fetch_valid, 0);
    check("async_mis", misalign_err, 0);
    check("async_cnt", redirect_cnt, 0);
    tick(); fetch_ready = 1'b1;
    rst = 1'b0;

    // Redirect during BOOT is ignored.
    redirect_valid = 1'b1; redirect_pc = 32'h300; #1;
    check("boot_redir_op", npc_op, 0);
    check("boot_redir_ex", flush_id_ex, 0);
    tick(); redirect_valid = 1'b0; #1;
    check("boot_redir_pc", pc, 32'h0);
    check("boot_redir_cnt", redirect_cnt, 0);
    check("boot_redir_flush", flush_if_id, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
